// File: rtl/voter_n_session.sv
// N-voter session controller: one vote per voter per session, registered pass/fail verdict.
// Optional session timeout is built only when VOTER_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no session yet (or after reset); waiting for start
// S_VOTE   | session open, accepting first vote from each voter (busy)
// S_RESULT | all voted (or timed out); verdict held until next start (done)
module voter_n_session #(
  parameter int NUM_VOTERS     = 3,
  parameter int THRESHOLD      = NUM_VOTERS / 2 + 1,
  parameter int TIMEOUT_CYCLES = 12_000_000,
  localparam int CW            = $clog2(NUM_VOTERS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_VOTERS-1:0] vote_valid,
  input  logic [NUM_VOTERS-1:0] vote_yes,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CW-1:0]         yes_cnt,
  output logic [NUM_VOTERS-1:0] voted,
  output logic                  timed_out
);

  if (NUM_VOTERS < 2 || NUM_VOTERS > 16) begin : g_bad_voters
    $error("voter_n_session: NUM_VOTERS out of range");
  end
  if (THRESHOLD < 1 || THRESHOLD > NUM_VOTERS) begin : g_bad_threshold
    $error("voter_n_session: THRESHOLD out of range");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("voter_n_session: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VOTE   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [NUM_VOTERS-1:0] accepted;
  logic [NUM_VOTERS-1:0] voted_nxt;
  logic [CW-1:0]         yes_sum;
  logic [CW-1:0]         yes_nxt;
  logic                  pass_nxt;
  logic                  all_in;
  logic                  expire;
  logic                  session_start;

  function automatic logic [CW-1:0] popcnt(input logic [NUM_VOTERS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Only first-time votes count; repeats are masked by the voted vector.
  assign accepted      = vote_valid & ~voted;
  assign yes_sum       = yes_cnt + popcnt(accepted & vote_yes);
  assign all_in        = &(voted | accepted);
  assign session_start = start && (state != S_VOTE);

  always_comb begin
    state_nxt = state;
    voted_nxt = voted;
    yes_nxt   = yes_cnt;
    pass_nxt  = pass;
    case (state)
      S_IDLE, S_RESULT: begin
        if (start) begin
          state_nxt = S_VOTE;
          voted_nxt = '0;
          yes_nxt   = '0;
          pass_nxt  = 1'b0;
        end
      end
      S_VOTE: begin
        voted_nxt = voted | accepted;
        yes_nxt   = yes_sum;
        // Completion wins over a timeout expiring in the same cycle.
        if (all_in || expire) begin
          state_nxt = S_RESULT;
          pass_nxt  = (yes_sum >= CW'(THRESHOLD));
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      yes_cnt <= '0;
      voted   <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt == S_VOTE);
      done    <= (state_nxt == S_RESULT);
      pass    <= pass_nxt;
      yes_cnt <= yes_nxt;
      voted   <= voted_nxt;
    end
  end

`ifdef VOTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmr;

  // Down-counter loaded on session entry; terminal count marks the last VOTE cycle.
  assign expire = (tmr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr       <= '0;
      timed_out <= 1'b0;
    end else if (session_start) begin
      tmr       <= TW'(TIMEOUT_CYCLES - 1);
      timed_out <= 1'b0;
    end else if (state == S_VOTE) begin
      if (!all_in && expire) begin
        timed_out <= 1'b1;
      end
      if (tmr != '0) begin
        tmr <= tmr - 1'b1;
      end
    end
  end
`else
  assign expire    = 1'b0;
  assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_voter_n_session.sv
// Bench for voter_n_session: vector table, corner-case sequences and a randomized
// run against a session-level reference model, on an N=3 and an N=5/THRESHOLD=4 instance.
module tb_voter_n_session;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] vv3 = '0, vy3 = '0;
  logic [4:0] vv5 = '0, vy5 = '0;

  logic       busy3, done3, pass3, tout3;
  logic [1:0] yc3;
  logic [2:0] voted3;
  logic       busy5, done5, pass5, tout5;
  logic [2:0] yc5;
  logic [4:0] voted5;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef VOTER_TIMEOUT_EN
  localparam int TMO3 = 8;
`else
  localparam int TMO3 = 0;
`endif

  always #5 clk = ~clk;

  voter_n_session #(.NUM_VOTERS(3), .TIMEOUT_CYCLES(8)) dut3 (
    .clk(clk), .rst(rst), .start(start), .vote_valid(vv3), .vote_yes(vy3),
    .busy(busy3), .done(done3), .pass(pass3), .yes_cnt(yc3), .voted(voted3),
    .timed_out(tout3)
  );

  voter_n_session #(.NUM_VOTERS(5), .THRESHOLD(4)) dut5 (
    .clk(clk), .rst(rst), .start(start), .vote_valid(vv5), .vote_yes(vy5),
    .busy(busy5), .done(done5), .pass(pass5), .yes_cnt(yc5), .voted(voted5),
    .timed_out(tout5)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic [2:0] vv;
    logic [2:0] vy;
    logic       busy;
    logic       done;
    logic       pass;
    logic       tout;
    logic [1:0] yc;
    logic [2:0] voted;
  } vec_t;

  typedef struct {
    int          phase;   // 0 idle, 1 voting, 2 verdict held
    logic [15:0] voted;
    int          yes;
    logic        pass;
    logic        tout;
    int          age;     // VOTE cycles already elapsed this session
  } mstate_t;

  vec_t    tbl[18];
  mstate_t m3, m5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic mstate_t mstep(mstate_t s, logic r, logic st, logic [15:0] vv,
                                    logic [15:0] vy, int n, int thr, int tmo);
    mstate_t     o;
    logic [15:0] all;
    o   = s;
    all = (16'h1 << n) - 16'h1;
    if (r) begin
      o = '{phase: 0, voted: '0, yes: 0, pass: 1'b0, tout: 1'b0, age: 0};
    end else if (s.phase == 1) begin
      for (int i = 0; i < n; i++) begin
        if (vv[i] && !s.voted[i]) begin
          o.voted[i] = 1'b1;
          if (vy[i]) o.yes = o.yes + 1;
        end
      end
      if (o.voted == all) begin
        o.phase = 2;
        o.pass  = (o.yes >= thr);
      end else if (tmo > 0 && s.age + 1 == tmo) begin
        o.phase = 2;
        o.tout  = 1'b1;
        o.pass  = (o.yes >= thr);
      end else begin
        o.age = s.age + 1;
      end
    end else if (st) begin
      o = '{phase: 1, voted: '0, yes: 0, pass: 1'b0, tout: 1'b0, age: 0};
    end
    return o;
  endfunction

  initial begin
    //            rst   start vv      vy      busy  done  pass  tout  yc     voted
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    tbl[1]  = '{1'b0, 1'b0, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    tbl[2]  = '{1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    tbl[3]  = '{1'b0, 1'b0, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'b010};
    tbl[4]  = '{1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'b011};
    tbl[5]  = '{1'b0, 1'b0, 3'b100, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 3'b111};
    tbl[6]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 3'b111};
    tbl[7]  = '{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 3'b111};
    tbl[8]  = '{1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    tbl[9]  = '{1'b0, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'b001};
    tbl[10] = '{1'b0, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'b001};
    tbl[11] = '{1'b0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 3'b111};
    tbl[12] = '{1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    tbl[13] = '{1'b0, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'b001};
    tbl[14] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    tbl[15] = '{1'b0, 1'b0, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    tbl[16] = '{1'b0, 1'b1, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    tbl[17] = '{1'b0, 1'b1, 3'b111, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 3'b111};

    for (int i = 0; i < 18; i++) begin
      rst   = tbl[i].rst;
      start = tbl[i].start;
      vv3   = tbl[i].vv;
      vy3   = tbl[i].vy;
      tick();
      chk($sformatf("tbl%0d_busy", i),  32'(busy3),  32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i),  32'(done3),  32'(tbl[i].done));
      chk($sformatf("tbl%0d_pass", i),  32'(pass3),  32'(tbl[i].pass));
      chk($sformatf("tbl%0d_tout", i),  32'(tout3),  32'(tbl[i].tout));
      chk($sformatf("tbl%0d_yc", i),    32'(yc3),    32'(tbl[i].yc));
      chk($sformatf("tbl%0d_voted", i), 32'(voted3), 32'(tbl[i].voted));
    end
    start = 1'b0; vv3 = '0; vy3 = '0;

    // N=5, THRESHOLD=4: 3 yes fails, then a restart from RESULT and 4 yes passes
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_reset_busy", 32'(busy5), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_start_busy", 32'(busy5), 32'd1);
    vv5 = 5'b11111; vy5 = 5'b00111; tick(); vv5 = '0; vy5 = '0;
    chk("t5_3yes_done", 32'(done5), 32'd1);
    chk("t5_3yes_pass", 32'(pass5), 32'd0);
    chk("t5_3yes_yc",   32'(yc5),   32'd3);
    chk("t5_3yes_busy", 32'(busy5), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_restart_busy", 32'(busy5), 32'd1);
    chk("t5_restart_yc",   32'(yc5),   32'd0);
    chk("t5_restart_done", 32'(done5), 32'd0);
    vv5 = 5'b01111; vy5 = 5'b01111; tick();
    chk("t5_4yes_yc",   32'(yc5),   32'd4);
    chk("t5_4yes_busy", 32'(busy5), 32'd1);
    vv5 = 5'b10000; vy5 = 5'b00000; tick(); vv5 = '0; vy5 = '0;
    chk("t5_4yes_done",  32'(done5),  32'd1);
    chk("t5_4yes_pass",  32'(pass5),  32'd1);
    chk("t5_4yes_yc2",   32'(yc5),    32'd4);
    chk("t5_4yes_voted", 32'(voted5), 32'h1f);

    // session with only voter0 voting
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    vv3 = 3'b001; vy3 = 3'b001; tick(); vv3 = '0; vy3 = '0;
    chk("to_vote_busy", 32'(busy3), 32'd1);
`ifdef VOTER_TIMEOUT_EN
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("to_wait%0d_busy", i), 32'(busy3), 32'd1);
    end
    tick();
    chk("to_exp_done",  32'(done3),  32'd1);
    chk("to_exp_tout",  32'(tout3),  32'd1);
    chk("to_exp_pass",  32'(pass3),  32'd0);
    chk("to_exp_yc",    32'(yc3),    32'd1);
    chk("to_exp_voted", 32'(voted3), 32'b001);
    // final vote lands in the expiry cycle: counted, not a timeout
    start = 1'b1; tick(); start = 1'b0;
    chk("to_restart_tout", 32'(tout3), 32'd0);
    chk("to_restart_busy", 32'(busy3), 32'd1);
    vv3 = 3'b011; vy3 = 3'b011; tick(); vv3 = '0; vy3 = '0;
    for (int i = 0; i < 6; i++) tick();
    chk("to_edge_busy", 32'(busy3), 32'd1);
    vv3 = 3'b100; vy3 = 3'b100; tick(); vv3 = '0; vy3 = '0;
    chk("to_edge_done", 32'(done3), 32'd1);
    chk("to_edge_tout", 32'(tout3), 32'd0);
    chk("to_edge_pass", 32'(pass3), 32'd1);
    chk("to_edge_yc",   32'(yc3),   32'd3);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("nto_wait_busy", 32'(busy3), 32'd1);
    chk("nto_wait_done", 32'(done3), 32'd0);
    chk("nto_wait_tout", 32'(tout3), 32'd0);
    vv3 = 3'b110; vy3 = 3'b000; tick(); vv3 = '0; vy3 = '0;
    chk("nto_close_done", 32'(done3), 32'd1);
    chk("nto_close_pass", 32'(pass3), 32'd0);
    chk("nto_close_yc",   32'(yc3),   32'd1);
`endif

    // randomized run against the session model
    m3 = '{phase: 0, voted: '0, yes: 0, pass: 1'b0, tout: 1'b0, age: 0};
    m5 = m3;
    for (int c = 0; c < 3000; c++) begin
      int dens;
      rst   = (c == 0) || ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 5) == 0);
      dens  = $urandom_range(1, 8);
      for (int b = 0; b < 3; b++) vv3[b] = ($urandom_range(0, dens) == 0);
      for (int b = 0; b < 5; b++) vv5[b] = ($urandom_range(0, dens) == 0);
      vy3 = 3'($urandom);
      vy5 = 5'($urandom);
      m3 = mstep(m3, rst, start, 16'(vv3), 16'(vy3), 3, 2, TMO3);
      m5 = mstep(m5, rst, start, 16'(vv5), 16'(vy5), 5, 4, 0);
      tick();
      chk("rnd3_busy",  32'(busy3),  32'(m3.phase == 1));
      chk("rnd3_done",  32'(done3),  32'(m3.phase == 2));
      chk("rnd3_pass",  32'(pass3),  32'(m3.pass));
      chk("rnd3_tout",  32'(tout3),  32'(m3.tout));
      chk("rnd3_yc",    32'(yc3),    32'(m3.yes));
      chk("rnd3_voted", 32'(voted3), 32'(m3.voted));
      chk("rnd5_busy",  32'(busy5),  32'(m5.phase == 1));
      chk("rnd5_done",  32'(done5),  32'(m5.phase == 2));
      chk("rnd5_pass",  32'(pass5),  32'(m5.pass));
      chk("rnd5_tout",  32'(tout5),  32'(m5.tout));
      chk("rnd5_yc",    32'(yc5),    32'(m5.yes));
      chk("rnd5_voted", 32'(voted5), 32'(m5.voted));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
